// File: rtl/serial_mod_scheduler.sv
// rtl/serial_mod_scheduler.sv - two-requester round-robin front end for a bit-serial mod-MODULUS residue tracker
module serial_mod_scheduler #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 5,
  localparam int RW     = ($clog2(MODULUS) < 1) ? 1 : $clog2(MODULUS),
  localparam int CW     = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             req1_ready_o,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_id_o,
  output logic [RW-1:0]    res_remainder_o,
  output logic             res_divisible_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [RW-1:0]    residue_q, residue_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;

  logic             grant;
  logic             accept;
  logic             last_bit;
  logic             res_fire;
  logic [RW:0]      t;

  // The pointer only matters when both requesters are valid at once.
  always_comb begin
    grant    = (req0_valid_i && req1_valid_i) ? ptr_q : req1_valid_i;
    accept   = (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    last_bit = (cnt_q == CW'(WIDTH - 1));
    res_fire = (state_q == DONE) && res_ready_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o    = accept && !grant;
    req1_ready_o    = accept && grant;
    serial_valid_o  = (state_q == SHIFT);
    serial_o        = serial_valid_o && shift_q[WIDTH-1];
    res_valid_o     = (state_q == DONE);
    res_id_o        = id_q;
    res_remainder_o = residue_q;
    res_divisible_o = (residue_q == '0);
    busy_o          = (state_q != IDLE);
  end

  // t never exceeds 2*MODULUS-1, so a single conditional subtract reduces it.
  always_comb begin
    t         = {residue_q, shift_q[WIDTH-1]};
    shift_d   = shift_q;
    residue_d = residue_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    if (accept) begin
      shift_d   = grant ? req1_data_i : req0_data_i;
      residue_d = '0;
      cnt_d     = '0;
      id_d      = grant;
    end else if (state_q == SHIFT) begin
      shift_d   = shift_q << 1;
      residue_d = (t >= (RW+1)'(MODULUS)) ? RW'(t - (RW+1)'(MODULUS)) : t[RW-1:0];
      cnt_d     = cnt_q + CW'(1);
    end
    if (res_fire) begin
      ptr_d = ~id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      residue_q <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      ptr_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      residue_q <= residue_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_serial_mod_scheduler.sv
// tb/tb_serial_mod_scheduler.sv - randomized self-checking bench for serial_mod_scheduler
module tb_serial_mod_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid_i = 1'b0;
  logic [7:0] req0_data_i = 8'h00;
  logic       req0_ready_o;
  logic       req1_valid_i = 1'b0;
  logic [7:0] req1_data_i = 8'h00;
  logic       req1_ready_o;
  logic       serial_o;
  logic       serial_valid_o;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;
  logic       res_id_o;
  logic [2:0] res_remainder_o;
  logic       res_divisible_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  serial_mod_scheduler #(.WIDTH(8), .MODULUS(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
    .serial_o(serial_o), .serial_valid_o(serial_valid_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
    .res_remainder_o(res_remainder_o), .res_divisible_o(res_divisible_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    res_ready_i  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_word(input int id, input logic [7:0] w, input int stall);
    logic [2:0] exp_rem;
    exp_rem = 3'(w % 5);
    @(negedge clk);
    if (id == 0) begin req0_valid_i = 1'b1; req0_data_i = w; end
    else begin req1_valid_i = 1'b1; req1_data_i = w; end
    #1;
    chk("accept_ready0", 32'(req0_ready_o), 32'(id == 0));
    chk("accept_ready1", 32'(req1_ready_o), 32'(id == 1));
    @(negedge clk);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("serial_valid", 32'(serial_valid_o), 1);
      chk("serial_bit", 32'(serial_o), 32'(w[7-i]));
      chk("shift_no_res", 32'(res_valid_o), 0);
      @(negedge clk);
    end
    #1;
    chk("res_valid", 32'(res_valid_o), 1);
    chk("res_id", 32'(res_id_o), 32'(id));
    chk("res_rem", 32'(res_remainder_o), 32'(exp_rem));
    chk("res_div", 32'(res_divisible_o), 32'(exp_rem == 0));
    req0_valid_i = (stall > 0);
    req1_valid_i = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 32'(res_valid_o), 1);
      chk("stall_rem", 32'(res_remainder_o), 32'(exp_rem));
      chk("stall_id", 32'(res_id_o), 32'(id));
      chk("stall_busy", 32'(busy_o), 1);
      chk("stall_no_ready", 32'({req0_ready_o, req1_ready_o}), 0);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    res_ready_i  = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    #1;
    chk("post_hs_valid", 32'(res_valid_o), 0);
    chk("post_hs_busy", 32'(busy_o), 0);
  endtask

  logic [7:0] pend0[$], pend1[$], iss0[$], iss1[$];
  int  gid[$], gcyc[$];

  initial begin
    int   cyc, done, acc_cyc, stray;
    logic ptr_m, outst, outst_id, v0, v1, exp_r0, exp_r1, exp_rv;
    logic [7:0] w;

    do_reset();
    #1;
    chk("rst_ready", 32'({req0_ready_o, req1_ready_o}), 0);
    chk("rst_serial", 32'({serial_o, serial_valid_o}), 0);
    chk("rst_res_valid", 32'(res_valid_o), 0);
    chk("rst_id", 32'(res_id_o), 0);
    chk("rst_rem", 32'(res_remainder_o), 0);
    chk("rst_div", 32'(res_divisible_o), 1);
    chk("rst_busy", 32'(busy_o), 0);

    send_word(0, 8'h5F, 0);
    send_word(1, 8'h17, 0);
    send_word(0, 8'h00, 0);
    send_word(1, 8'hFF, 3);

    // Reset in the middle of shifting 0x5F.
    @(negedge clk);
    req0_valid_i = 1'b1;
    req0_data_i  = 8'h5F;
    @(negedge clk);
    req0_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_serial", 32'({serial_o, serial_valid_o}), 0);
    chk("midrst_res_valid", 32'(res_valid_o), 0);
    chk("midrst_rem", 32'(res_remainder_o), 0);
    chk("midrst_div", 32'(res_divisible_o), 1);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    res_ready_i = 1'b1;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (res_valid_o) stray++;
    end
    res_ready_i = 1'b0;
    chk("midrst_no_result", 32'(stray), 0);
    send_word(0, 8'h0A, 0);

    // Fairness with both requesters always valid.
    do_reset();
    res_ready_i = 1'b1;
    for (int c = 0; c < 80 && gid.size() < 4; c++) begin
      @(negedge clk);
      req0_valid_i = 1'b1; req0_data_i = 8'h33;
      req1_valid_i = 1'b1; req1_data_i = 8'h44;
      #1;
      if (req0_ready_o && req1_ready_o) chk("fair_both_ready", 1, 0);
      if (req0_ready_o || req1_ready_o) begin
        gid.push_back(int'(req1_ready_o));
        gcyc.push_back(c);
      end
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    chk("fair_grants", 32'(gid.size()), 4);
    for (int i = 0; i < gid.size(); i++) begin
      chk("fair_id", 32'(gid[i]), 32'(i % 2));
      if (i > 0) chk("fair_interval", 32'(gcyc[i] - gcyc[i-1]), 10);
    end
    repeat (12) @(negedge clk);
    res_ready_i = 1'b0;

    // Random sweep against a queue-based model.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      w = 8'($urandom);
      if ($urandom % 2 == 0) pend0.push_back(w); else pend1.push_back(w);
    end
    ptr_m = 1'b0; outst = 1'b0; outst_id = 1'b0; acc_cyc = 0; done = 0;
    for (cyc = 0; cyc < 40000 && done < 1000; cyc++) begin
      @(negedge clk);
      v0 = (pend0.size() > 0) && ($urandom % 4 != 0);
      v1 = (pend1.size() > 0) && ($urandom % 4 != 0);
      req0_valid_i = v0;
      req0_data_i  = (pend0.size() > 0) ? pend0[0] : 8'($urandom);
      req1_valid_i = v1;
      req1_data_i  = (pend1.size() > 0) ? pend1[0] : 8'($urandom);
      res_ready_i  = ($urandom % 3 != 0);
      #1;
      exp_r0 = !outst && v0 && (!v1 || !ptr_m);
      exp_r1 = !outst && v1 && (!v0 || ptr_m);
      exp_rv = outst && (cyc >= acc_cyc + 9);
      chk("rnd_ready0", 32'(req0_ready_o), 32'(exp_r0));
      chk("rnd_ready1", 32'(req1_ready_o), 32'(exp_r1));
      chk("rnd_res_valid", 32'(res_valid_o), 32'(exp_rv));
      if (exp_rv && res_ready_i) begin
        w = outst_id ? iss1.pop_front() : iss0.pop_front();
        chk("rnd_id", 32'(res_id_o), 32'(outst_id));
        chk("rnd_rem", 32'(res_remainder_o), 32'(w % 5));
        chk("rnd_div", 32'(res_divisible_o), 32'((w % 5) == 0));
        ptr_m = !outst_id;
        outst = 1'b0;
        done++;
      end
      if (exp_r0) begin
        iss0.push_back(pend0.pop_front());
        outst = 1'b1; outst_id = 1'b0; acc_cyc = cyc;
      end else if (exp_r1) begin
        iss1.push_back(pend1.pop_front());
        outst = 1'b1; outst_id = 1'b1; acc_cyc = cyc;
      end
    end
    chk("rnd_done", 32'(done), 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
